mem_writer: RTL

MEM_WRITER -- requirements
Module: mem_writer

---
 rtl/mem_writer_if.sv | 30 +++
 rtl/mem_writer.sv | 97 +++++++++
 2 files changed

// File: rtl/mem_writer_if.sv
// mem_writer_if: burst request, upstream stream and memory write bus of mem_writer.
interface mem_writer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   len;
   logic              abort;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   count;

   modport master (
      output start, start_addr, len, abort, in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, count
   );

   modport slave (
      input  start, start_addr, len, abort, in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, busy, done, err, count
   );
endinterface

// File: rtl/mem_writer.sv
// mem_writer: accepts a burst request, then writes len upstream words to consecutive
// (wrapping) memory addresses with one cycle of latency, supporting abort.
module mem_writer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input logic         clk,
   input logic         rst_n,
   mem_writer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]   rem_q, rem_d, count_q, count_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              in_ready_q, in_ready_d, wr_en_q, wr_en_d;
   logic              done_q, done_d, err_q, err_d;
   logic              beat, len_ok;

   always_comb begin
      beat      = state_q == WRITE && bus.in_valid && !bus.abort;
      len_ok    = bus.len != '0 && bus.len <= DEPTH;
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      count_d   = count_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = beat;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            if (len_ok) begin
               state_d = WRITE;
               addr_d  = bus.start_addr;
               rem_d   = bus.len;
               count_d = '0;
            end else err_d = 1'b1;
         end
         WRITE: if (bus.abort) state_d = IDLE;
         else if (beat) begin
            wr_addr_d = addr_q;
            wr_data_d = bus.in_data;
            addr_d    = addr_q + 1'b1;
            rem_d     = rem_q - ONE;
            count_d   = count_q + ONE;
            // done is registered alongside the last write strobe
            if (rem_q == ONE) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = state_d == WRITE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         count_q    <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         count_q    <= count_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         in_ready_q <= in_ready_d;
         wr_en_q    <= wr_en_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = state_q != IDLE;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.count    = count_q;
endmodule
